serial_word_collector: RTL and testbench
========================================

Name: serial_word_collector

Overview:
- Deserializing stage directly downstream of the 32-bit shift register. Consumes its srl_out bit stream, qualified by a per-bit strobe.
- Reassembles WIDTH-bit words and buffers them in a small FIFO.
- Presents words on a valid/ready interface to the next consumer.
- Reports buffer fill level and a sticky overflow flag when words are lost.

Parameters:
- WIDTH, 32, bits per assembled word; must be >= 2.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- MSB_FIRST, 1, 1 = first received bit lands in word bit WIDTH-1; 0 = first bit lands in bit 0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_vld  input  1  bit_in is valid this cycle.
- bit_in  input  1  serial data bit (driven from shift-register srl_out).
- frame_sync  input  1  start-of-word marker; qualified by bit_vld.
- word_out  output  WIDTH  head-of-FIFO word.
- word_vld  output  1  word_out valid.
- word_rdy  input  1  consumer accepts word_out when word_vld && word_rdy.
- fill_level  output  $clog2(DEPTH)+1  number of words held in the FIFO.
- overflow  output  1  sticky: a completed word was dropped.
- clear_ovf  input  1  clears overflow.

Behaviour:
- Reset (rst=1 at an edge) forces:
  - word_vld=0, word_out=0, fill_level=0, overflow=0.
  - Bit counter=0 and assembly register=0.
  - Any partially assembled word and all FIFO contents are discarded.
  - rst overrides every other input in the same cycle.
- Assembly:
  - bit counter cnt in 0..WIDTH-1 counts accepted bits (bit_vld=1).
  - MSB_FIRST=1: asm <= {asm[WIDTH-2:0], bit_in}.
  - MSB_FIRST=0: asm <= {bit_in, asm[WIDTH-1:1]}.
  - Cycles with bit_vld=0 change nothing; gaps between bits are allowed.
- Word completion:
  - Occurs when bit_vld=1 and cnt==WIDTH-1. The completed word includes the current bit_in.
  - cnt wraps to 0 on completion.
  - The completed word is pushed into the FIFO at that same edge.
  - Latency: word_vld=1 in the cycle after the edge that accepted the last bit, when the FIFO was previously empty.
- frame_sync:
  - When frame_sync=1 and bit_vld=1, the partial word is discarded. bit_in becomes bit 0 of a new word, so cnt becomes 1 and asm holds only that bit.
  - frame_sync with bit_vld=0 is ignored.
  - frame_sync when cnt==WIDTH-1 also discards the partial word; no push occurs.
- FIFO:
  - Show-ahead: word_out is the head entry, registered; no combinational path from bit_in to word_out.
  - Pop when word_vld && word_rdy.
  - word_out holds its value while word_vld=1 and word_rdy=0.
  - word_out is don't-care (holds last value) when word_vld=0.
- Simultaneous events:
  - Push and pop in one cycle: fill_level unchanged. This is legal when full, because the pop frees a slot and no overflow is raised.
  - Push and pop when empty: the pop is impossible (word_vld=0), so the new word is held.
- Overflow:
  - A completed word arriving with fill_level==DEPTH and no pop that cycle is dropped.
  - The drop sets overflow=1 from the next cycle; FIFO contents are untouched.
  - clear_ovf=1 clears overflow next cycle.
  - clear_ovf and a new drop in the same cycle: set wins.
- fill_level stays within 0..DEPTH.
- Pointers wrap modulo DEPTH.

Decomposition:
- Package serial_word_pkg holds:
  - function cnt_w(WIDTH) returning $clog2(WIDTH);
  - function lvl_w(DEPTH) returning $clog2(DEPTH)+1;
  - localparam bit ORDER_MSB=1'b1, ORDER_LSB=1'b0.
- One sub-module, word_fifo (WIDTH, DEPTH parameters): a synchronous show-ahead FIFO with push/pop/full/empty/level.
- Assembly and overflow logic stay in the top.

Test Plan:
- MSB_FIRST=1: after reset, send 32 consecutive bits of 0xDEADBEEF MSB first with word_rdy=1 -> word_vld=1 with word_out=0xDEADBEEF exactly one cycle after the last bit; fill_level returns to 0 after the pop.
- MSB_FIRST=0: send 0x12345678 LSB first with random bit_vld gaps (~50% duty) -> word_out=0x12345678.
- Hold word_rdy=0 and send 5 words 0x1..0x5 with DEPTH=4 -> fill_level=4 and overflow=1 after the 5th completes; drain yields 0x1..0x4 in order. clear_ovf then gives overflow=0.
- FIFO full with word_rdy=1 in the exact completion cycle of a new word 0xA5A5A5A5 -> no overflow, fill_level stays 4, 0xA5A5A5A5 emerges last.
- Send 10 bits of garbage, then frame_sync=1 with the first bit of 0xCAFEF00D -> the next word out is 0xCAFEF00D; no word is emitted for the garbage bits.
- Assert rst mid-word (after 17 bits) while the FIFO holds 2 words -> next cycle word_vld=0, fill_level=0, overflow=0; a subsequent 32-bit 0x0000FFFF assembles correctly from bit 0.

Source files
------------

// File: rtl/serial_word_pkg.sv
// rtl/serial_word_pkg.sv - shared width helpers and bit-order constants for the serial word collector
package serial_word_pkg;

  localparam bit ORDER_MSB = 1'b1;
  localparam bit ORDER_LSB = 1'b0;

  // Bits needed to count 0..width-1 received bits.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

  // Bits needed to express a fill level of 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/serial_word_collector_if.sv
// rtl/serial_word_collector_if.sv - bit-stream input, word handshake output and status bundle
interface serial_word_collector_if
  import serial_word_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);

  logic                      bit_vld;
  logic                      bit_in;
  logic                      frame_sync;
  logic [WIDTH-1:0]          word_out;
  logic                      word_vld;
  logic                      word_rdy;
  logic [lvl_w(DEPTH)-1:0]   fill_level;
  logic                      overflow;
  logic                      clear_ovf;

  // Producer of bits and consumer of words.
  modport master (
    output bit_vld, bit_in, frame_sync, word_rdy, clear_ovf,
    input  word_out, word_vld, fill_level, overflow
  );

  // The collector itself.
  modport slave (
    input  bit_vld, bit_in, frame_sync, word_rdy, clear_ovf,
    output word_out, word_vld, fill_level, overflow
  );

endinterface

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - synchronous show-ahead FIFO with a registered head word
module word_fifo
  import serial_word_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic                    full,
  output logic                    empty,
  output logic [lvl_w(DEPTH)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_next;
  logic [LW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign rd_next = rd_ptr + PW'(1);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_push = push && (!full || do_pop);

  // Storage array; contents need no reset because the pointers and count do.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; power-of-two depth makes pointer wrap natural.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Head register: loads the word that will be at the front after this edge, else holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
    end else if (do_push && (empty || (do_pop && cnt == LW'(1)))) begin
      head <= push_data;
    end else if (do_pop && cnt >= LW'(2)) begin
      head <= mem[rd_next];
    end
  end

endmodule

// File: rtl/serial_word_collector.sv
// rtl/serial_word_collector.sv - reassembles strobed serial bits into words and buffers them
module serial_word_collector
  import serial_word_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = ORDER_MSB
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_word_collector_if.slave  bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] asm_reg;
  logic [WIDTH-1:0] asm_next;
  logic             complete;
  logic             pop;
  logic             full;
  logic             empty;
  logic             drop;
  logic             ovf_reg;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST == ORDER_MSB) return {cur[WIDTH-2:0], b};
    else                        return {b, cur[WIDTH-1:1]};
  endfunction

  // Next assembly value; a frame_sync restarts from an empty word holding only bit_in.
  always_comb begin
    asm_next = shift_in(bus.frame_sync ? '0 : asm_reg, bus.bit_in);
    complete = bus.bit_vld && !bus.frame_sync && (cnt == CNT_LAST);
    pop      = bus.word_vld && bus.word_rdy;
    drop     = complete && full && !pop;
  end

  // Bit counter and assembly register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      asm_reg <= '0;
    end else if (bus.bit_vld) begin
      if (bus.frame_sync) begin
        cnt     <= CW'(1);
        asm_reg <= asm_next;
      end else if (complete) begin
        cnt     <= '0;
        asm_reg <= '0;
      end else begin
        cnt     <= cnt + CW'(1);
        asm_reg <= asm_next;
      end
    end
  end

  // Sticky overflow; a new drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (drop) begin
      ovf_reg <= 1'b1;
    end else if (bus.clear_ovf) begin
      ovf_reg <= 1'b0;
    end
  end

  word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (complete),
    .push_data (asm_next),
    .pop       (pop),
    .head      (bus.word_out),
    .full      (full),
    .empty     (empty),
    .level     (bus.fill_level)
  );

  assign bus.word_vld = !empty;
  assign bus.overflow = ovf_reg;

endmodule

// File: tb/tb_serial_word_collector.sv
// tb/tb_serial_word_collector.sv - directed self-checking bench for serial_word_collector
module tb_serial_word_collector;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_word_collector_if #(.WIDTH(32), .DEPTH(4)) a_if ();
  serial_word_collector_if #(.WIDTH(32), .DEPTH(4)) b_if ();

  serial_word_collector #(.WIDTH(32), .DEPTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  serial_word_collector #(.WIDTH(32), .DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_bit(input logic b, input logic fs);
    @(negedge clk);
    a_if.bit_vld    = 1'b1;
    a_if.bit_in     = b;
    a_if.frame_sync = fs;
  endtask

  task automatic idle();
    @(negedge clk);
    a_if.bit_vld    = 1'b0;
    a_if.bit_in     = 1'b0;
    a_if.frame_sync = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic fs_first);
    for (int i = 31; i >= 0; i--) drive_bit(w[i], (i == 31) ? fs_first : 1'b0);
  endtask

  task automatic drain_one(input logic [31:0] exp, input string name);
    checks++;
    if (a_if.word_vld !== 1'b1 || a_if.word_out !== exp) begin
      errors++;
      $display("FAIL %s: vld=%b word=%h expected vld=1 word=%h", name, a_if.word_vld, a_if.word_out, exp);
    end
    a_if.word_rdy = 1'b1;
    @(negedge clk);
    a_if.word_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_if.bit_vld = 1'b1;
    a_if.bit_in  = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (a_if.word_vld !== 1'b0 || a_if.word_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_word: vld=%b word=%h expected vld=0 word=0", a_if.word_vld, a_if.word_out);
    end
    checks++;
    if (a_if.fill_level !== 3'd0 || a_if.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: fill=%0d ovf=%b expected fill=0 ovf=0", a_if.fill_level, a_if.overflow);
    end
    checks++;
    if (b_if.word_vld !== 1'b0 || b_if.fill_level !== 3'd0 || b_if.word_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_lsb: vld=%b fill=%0d word=%h expected 0/0/0", b_if.word_vld, b_if.fill_level, b_if.word_out);
    end
    rst = 1'b0;
    a_if.bit_vld = 1'b0;
    a_if.bit_in  = 1'b0;
  endtask

  task automatic test_msb_first();
    a_if.word_rdy = 1'b1;
    send_word(32'hDEADBEEF, 1'b0);
    idle();
    checks++;
    if (a_if.word_vld !== 1'b1 || a_if.word_out !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL msb_word: vld=%b word=%h expected vld=1 word=deadbeef", a_if.word_vld, a_if.word_out);
    end
    @(negedge clk);
    checks++;
    if (a_if.fill_level !== 3'd0 || a_if.word_vld !== 1'b0) begin
      errors++;
      $display("FAIL msb_popped: fill=%0d vld=%b expected fill=0 vld=0", a_if.fill_level, a_if.word_vld);
    end
    a_if.word_rdy = 1'b0;
  endtask

  task automatic test_lsb_first();
    logic [31:0] w;
    w = 32'h12345678;
    b_if.word_rdy = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        b_if.bit_vld = 1'b0;
      end
      @(negedge clk);
      b_if.bit_vld = 1'b1;
      b_if.bit_in  = w[i];
    end
    @(negedge clk);
    b_if.bit_vld = 1'b0;
    checks++;
    if (b_if.word_vld !== 1'b1 || b_if.word_out !== 32'h12345678) begin
      errors++;
      $display("FAIL lsb_word: vld=%b word=%h expected vld=1 word=12345678", b_if.word_vld, b_if.word_out);
    end
    @(negedge clk);
    checks++;
    if (b_if.fill_level !== 3'd0) begin
      errors++;
      $display("FAIL lsb_popped: fill=%0d expected 0", b_if.fill_level);
    end
    b_if.word_rdy = 1'b0;
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 4; k++) send_word(32'(k), 1'b0);
    idle();
    checks++;
    if (a_if.fill_level !== 3'd4 || a_if.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: fill=%0d ovf=%b expected fill=4 ovf=0", a_if.fill_level, a_if.overflow);
    end
    send_word(32'h5, 1'b0);
    idle();
    checks++;
    if (a_if.fill_level !== 3'd4 || a_if.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: fill=%0d ovf=%b expected fill=4 ovf=1", a_if.fill_level, a_if.overflow);
    end
    a_if.clear_ovf = 1'b1;
    @(negedge clk);
    a_if.clear_ovf = 1'b0;
    checks++;
    if (a_if.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b expected 0", a_if.overflow);
    end
    send_word(32'h6, 1'b0);
    a_if.clear_ovf = 1'b1;
    idle();
    a_if.clear_ovf = 1'b0;
    checks++;
    if (a_if.overflow !== 1'b1 || a_if.fill_level !== 3'd4) begin
      errors++;
      $display("FAIL ovf_set_wins: ovf=%b fill=%0d expected ovf=1 fill=4", a_if.overflow, a_if.fill_level);
    end
    drain_one(32'h1, "ovf_drain1");
    drain_one(32'h2, "ovf_drain2");
    drain_one(32'h3, "ovf_drain3");
    drain_one(32'h4, "ovf_drain4");
    checks++;
    if (a_if.word_vld !== 1'b0 || a_if.fill_level !== 3'd0) begin
      errors++;
      $display("FAIL ovf_empty: vld=%b fill=%0d expected vld=0 fill=0", a_if.word_vld, a_if.fill_level);
    end
    a_if.clear_ovf = 1'b1;
    @(negedge clk);
    a_if.clear_ovf = 1'b0;
    checks++;
    if (a_if.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_final_clear: ovf=%b expected 0", a_if.overflow);
    end
  endtask

  task automatic test_full_push_pop();
    send_word(32'h11, 1'b0);
    send_word(32'h22, 1'b0);
    send_word(32'h33, 1'b0);
    send_word(32'h44, 1'b0);
    send_word(32'hA5A5A5A5, 1'b0);
    a_if.word_rdy = 1'b1;
    idle();
    a_if.word_rdy = 1'b0;
    checks++;
    if (a_if.overflow !== 1'b0 || a_if.fill_level !== 3'd4 || a_if.word_out !== 32'h22) begin
      errors++;
      $display("FAIL full_push_pop: ovf=%b fill=%0d word=%h expected ovf=0 fill=4 word=00000022",
               a_if.overflow, a_if.fill_level, a_if.word_out);
    end
    drain_one(32'h22, "full_drain1");
    drain_one(32'h33, "full_drain2");
    drain_one(32'h44, "full_drain3");
    drain_one(32'hA5A5A5A5, "full_drain4");
  endtask

  task automatic test_frame_sync();
    logic [9:0] junk;
    junk = 10'b1011011101;
    a_if.word_rdy = 1'b1;
    for (int i = 9; i >= 0; i--) drive_bit(junk[i], 1'b0);
    send_word(32'hCAFEF00D, 1'b1);
    idle();
    checks++;
    if (a_if.word_vld !== 1'b1 || a_if.word_out !== 32'hCAFEF00D || a_if.fill_level !== 3'd1) begin
      errors++;
      $display("FAIL sync_word: vld=%b word=%h fill=%0d expected vld=1 word=cafef00d fill=1",
               a_if.word_vld, a_if.word_out, a_if.fill_level);
    end
    @(negedge clk);
    checks++;
    if (a_if.word_vld !== 1'b0 || a_if.fill_level !== 3'd0) begin
      errors++;
      $display("FAIL sync_no_extra: vld=%b fill=%0d expected vld=0 fill=0", a_if.word_vld, a_if.fill_level);
    end
    a_if.word_rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [16:0] part;
    part = 17'h1A5C3;
    send_word(32'h11112222, 1'b0);
    send_word(32'h33334444, 1'b0);
    for (int i = 16; i >= 0; i--) drive_bit(part[i], 1'b0);
    checks++;
    if (a_if.fill_level !== 3'd2) begin
      errors++;
      $display("FAIL mid_pre_fill: fill=%0d expected 2", a_if.fill_level);
    end
    @(negedge clk);
    rst = 1'b1;
    a_if.bit_vld = 1'b1;
    a_if.bit_in  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_if.bit_vld = 1'b0;
    a_if.bit_in  = 1'b0;
    checks++;
    if (a_if.word_vld !== 1'b0 || a_if.fill_level !== 3'd0 || a_if.overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: vld=%b fill=%0d ovf=%b expected 0/0/0", a_if.word_vld, a_if.fill_level, a_if.overflow);
    end
    a_if.word_rdy = 1'b1;
    send_word(32'h0000FFFF, 1'b0);
    idle();
    checks++;
    if (a_if.word_vld !== 1'b1 || a_if.word_out !== 32'h0000FFFF) begin
      errors++;
      $display("FAIL mid_reassemble: vld=%b word=%h expected vld=1 word=0000ffff", a_if.word_vld, a_if.word_out);
    end
    @(negedge clk);
    a_if.word_rdy = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a_if.bit_vld = 1'b0; a_if.bit_in = 1'b0; a_if.frame_sync = 1'b0;
    a_if.word_rdy = 1'b0; a_if.clear_ovf = 1'b0;
    b_if.bit_vld = 1'b0; b_if.bit_in = 1'b0; b_if.frame_sync = 1'b0;
    b_if.word_rdy = 1'b0; b_if.clear_ovf = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overflow();
    test_full_push_pop();
    test_frame_sync();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
